// File: rtl/ctrl_tx.sv
// TX-side controller: buffers RegFile/ALU result strobes and frames them as bytes into the TX FIFO.
// Optional TX_CHECKSUM_EN appends an XOR checksum byte to every frame.
module ctrl_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ALU_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     RdData,
    input  logic                 RdData_Valid,
    input  logic [ALU_WIDTH-1:0] ALU_OUT,
    input  logic                 OUT_VALID,
    input  logic                 FIFO_FULL,
    output logic [WIDTH-1:0]     WR_DATA,
    output logic                 WR_INC,
    output logic                 BUSY,
    output logic                 OVERRUN
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_RD  = 3'd1,
        SEND_LO  = 3'd2,
        SEND_HI  = 3'd3,
        SEND_CHK = 3'd4
    } state_t;

    state_t               state;
    logic                 rd_pend;
    logic [WIDTH-1:0]     rd_buf;
    logic                 alu_pend;
    logic [ALU_WIDTH-1:0] alu_buf;
    logic [ALU_WIDTH-1:0] frm;
    logic                 rd_load;
    logic                 alu_load;
    logic [WIDTH-1:0]     lo_byte;
    logic [WIDTH-1:0]     hi_byte;

    // Pending buffers are consumed only from IDLE; register reads take priority.
    assign rd_load  = (state == IDLE) && rd_pend;
    assign alu_load = (state == IDLE) && !rd_pend && alu_pend;
    assign lo_byte  = frm[WIDTH-1:0];
    assign hi_byte  = frm[ALU_WIDTH-1:WIDTH];

    // FIFO write port is driven straight from the frame state.
    always_comb begin
        WR_DATA = '0;
        case (state)
            SEND_RD, SEND_LO: WR_DATA = lo_byte;
            SEND_HI:          WR_DATA = hi_byte;
`ifdef TX_CHECKSUM_EN
            SEND_CHK:         WR_DATA = lo_byte ^ hi_byte;
`endif
            default:          WR_DATA = '0;
        endcase
    end

    assign WR_INC = (state != IDLE) && !FIFO_FULL;
    assign BUSY   = (state != IDLE) || rd_pend || alu_pend;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            rd_pend  <= 1'b0;
            rd_buf   <= '0;
            alu_pend <= 1'b0;
            alu_buf  <= '0;
            frm      <= '0;
            OVERRUN  <= 1'b0;
        end else begin
            // A strobe landing on the load edge refills the buffer; otherwise a full buffer drops it.
            if (RdData_Valid) begin
                if (rd_pend && !rd_load) begin
                    OVERRUN <= 1'b1;
                end else begin
                    rd_pend <= 1'b1;
                    rd_buf  <= RdData;
                end
            end else if (rd_load) begin
                rd_pend <= 1'b0;
            end

            if (OUT_VALID) begin
                if (alu_pend && !alu_load) begin
                    OVERRUN <= 1'b1;
                end else begin
                    alu_pend <= 1'b1;
                    alu_buf  <= ALU_OUT;
                end
            end else if (alu_load) begin
                alu_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rd_load) begin
                        frm   <= ALU_WIDTH'(rd_buf);
                        state <= SEND_RD;
                    end else if (alu_load) begin
                        frm   <= alu_buf;
                        state <= SEND_LO;
                    end
                end
                SEND_RD: begin
                    if (WR_INC) begin
`ifdef TX_CHECKSUM_EN
                        state <= SEND_CHK;
`else
                        state <= IDLE;
`endif
                    end
                end
                SEND_LO: begin
                    if (WR_INC) state <= SEND_HI;
                end
                SEND_HI: begin
                    if (WR_INC) begin
`ifdef TX_CHECKSUM_EN
                        state <= SEND_CHK;
`else
                        state <= IDLE;
`endif
                    end
                end
                default: begin
                    if (WR_INC) state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_tx.sv
// Directed vector bench for ctrl_tx; expectations follow the TX_CHECKSUM_EN setting of the build.
module tb_ctrl_tx;

    logic        CLK;
    logic        RST;
    logic [7:0]  RdData;
    logic        RdData_Valid;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic        FIFO_FULL;
    logic [7:0]  WR_DATA;
    logic        WR_INC;
    logic        BUSY;
    logic        OVERRUN;

    ctrl_tx #(.WIDTH(8), .ALU_WIDTH(16)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .ALU_OUT      (ALU_OUT),
        .OUT_VALID    (OUT_VALID),
        .FIFO_FULL    (FIFO_FULL),
        .WR_DATA      (WR_DATA),
        .WR_INC       (WR_INC),
        .BUSY         (BUSY),
        .OVERRUN      (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [7:0]  rd;
        logic        ov;
        logic [15:0] alu;
        logic        ff;
        logic        inc;
        logic [7:0]  data;
        logic        busy;
        logic        ovr;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic v(input logic rst, input logic rv, input logic [7:0] rd,
                     input logic ov, input logic [15:0] alu, input logic ff,
                     input logic inc, input logic [7:0] data, input logic busy, input logic ovr);
        vec_t t;
        t.rst = rst; t.rv = rv; t.rd = rd; t.ov = ov; t.alu = alu; t.ff = ff;
        t.inc = inc; t.data = data; t.busy = busy; t.ovr = ovr;
        tbl.push_back(t);
    endtask

    // Cycle with no strobes and reset released.
    task automatic e(input logic ff, input logic inc, input logic [7:0] data,
                     input logic busy, input logic ovr);
        v(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, ff, inc, data, busy, ovr);
    endtask

    task automatic drive(input logic rst, input logic rv, input logic [7:0] rd,
                         input logic ov, input logic [15:0] alu, input logic ff);
        RST = rst; RdData_Valid = rv; RdData = rd; OUT_VALID = ov; ALU_OUT = alu; FIFO_FULL = ff;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] got[$];
        logic [7:0] want[$];

        drive(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);

        // reset and idle
        v(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        e(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        e(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // register read 5A
        v(1'b1, 1'b1, 8'h5A, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        e(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        e(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
`ifdef TX_CHECKSUM_EN
        e(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
`endif
        e(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // ALU 1234
        v(1'b1, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        e(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        e(1'b0, 1'b1, 8'h34, 1'b1, 1'b0);
        e(1'b0, 1'b1, 8'h12, 1'b1, 1'b0);
`ifdef TX_CHECKSUM_EN
        e(1'b0, 1'b1, 8'h26, 1'b1, 1'b0);
`endif
        e(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // simultaneous A1 and BEEF: read frame first, ALU waits in pending
        v(1'b1, 1'b1, 8'hA1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        e(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        e(1'b0, 1'b1, 8'hA1, 1'b1, 1'b0);
`ifdef TX_CHECKSUM_EN
        e(1'b0, 1'b1, 8'hA1, 1'b1, 1'b0);
`endif
        e(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        e(1'b0, 1'b1, 8'hEF, 1'b1, 1'b0);
        e(1'b0, 1'b1, 8'hBE, 1'b1, 1'b0);
`ifdef TX_CHECKSUM_EN
        e(1'b0, 1'b1, 8'h51, 1'b1, 1'b0);
`endif
        e(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // CAFE with a 5-cycle stall after the low byte
        v(1'b1, 1'b0, 8'h00, 1'b1, 16'hCAFE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        e(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        e(1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) e(1'b1, 1'b0, 8'hCA, 1'b1, 1'b0);
        e(1'b0, 1'b1, 8'hCA, 1'b1, 1'b0);
`ifdef TX_CHECKSUM_EN
        e(1'b0, 1'b1, 8'h34, 1'b1, 1'b0);
`endif
        e(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // overrun: 0001 framed, 0002 pending, 0003 dropped
        v(1'b1, 1'b0, 8'h00, 1'b1, 16'h0001, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        e(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        v(1'b1, 1'b0, 8'h00, 1'b1, 16'h0002, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        v(1'b1, 1'b0, 8'h00, 1'b1, 16'h0003, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        e(1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
        e(1'b0, 1'b1, 8'h01, 1'b1, 1'b1);
        e(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
`ifdef TX_CHECKSUM_EN
        e(1'b0, 1'b1, 8'h01, 1'b1, 1'b1);
`endif
        e(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        e(1'b0, 1'b1, 8'h02, 1'b1, 1'b1);
        e(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
`ifdef TX_CHECKSUM_EN
        e(1'b0, 1'b1, 8'h02, 1'b1, 1'b1);
`endif
        e(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // reset while stalled in the high byte, then 20 quiet cycles
        v(1'b1, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        e(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        e(1'b0, 1'b1, 8'h34, 1'b1, 1'b1);
        e(1'b1, 1'b0, 8'h12, 1'b1, 1'b1);
        v(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) e(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Inputs change at the falling edge; outputs are sampled 1 time unit later.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            drive(tbl[i].rst, tbl[i].rv, tbl[i].rd, tbl[i].ov, tbl[i].alu, tbl[i].ff);
            #1;
            check($sformatf("vec%0d inc/data/busy/ovr", i),
                  32'({WR_INC, WR_DATA, BUSY, OVERRUN}),
                  32'({tbl[i].inc, tbl[i].data, tbl[i].busy, tbl[i].ovr}));
        end

        // Read strobe on the edge its pending flag is consumed: the new byte is kept.
        @(negedge CLK);
        drive(1'b1, 1'b1, 8'h11, 1'b0, 16'h0000, 1'b0);
        @(negedge CLK);
        drive(1'b1, 1'b1, 8'h22, 1'b0, 16'h0000, 1'b0);
        @(negedge CLK);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        for (int c = 0; c < 12; c++) begin
            #1;
            if (WR_INC) got.push_back(WR_DATA);
            @(negedge CLK);
        end
        want.push_back(8'h11);
`ifdef TX_CHECKSUM_EN
        want.push_back(8'h11);
`endif
        want.push_back(8'h22);
`ifdef TX_CHECKSUM_EN
        want.push_back(8'h22);
`endif
        check("setwins byte count", 32'(got.size()), 32'(want.size()));
        for (int k = 0; k < want.size(); k++) begin
            if (k < got.size()) check($sformatf("setwins byte%0d", k), 32'(got[k]), 32'(want[k]));
            else check($sformatf("setwins byte%0d missing", k), 32'hFFFF_FFFF, 32'(want[k]));
        end
        #1;
        check("setwins overrun", 32'(OVERRUN), 32'd0);
        check("setwins busy", 32'(BUSY), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
